// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle sequencer for the IcyRisc RV32I core.
// Walks each instruction through fetch, decode, execute, memory and
// writeback, and drives the shared ALU, memory port and register file.
// Optional build macro: ICYRISC_ILLEGAL_TRAP_EN adds the 'illegal' output and
// a TRAP state that unknown opcodes fall into until reset.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               adr_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [2:0]         imm_ctrl,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         result_src,
`ifdef ICYRISC_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JALR   = 4'd10,
        JAL    = 4'd11,
        LUI    = 4'd12,
        AUIPC  = 4'd13
`ifdef ICYRISC_ILLEGAL_TRAP_EN
        ,
        TRAP   = 4'd14
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register; reset always lands in FETCH, even mid memory access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; stalls hold FETCH/MEMRD/MEMWR until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
`ifdef ICYRISC_ILLEGAL_TRAP_EN
                    default:           state_d = TRAP;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LOAD) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH;
            EXEC_R:  state_d = ALUWB;
            EXEC_I:  state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JALR:    state_d = JAL;
            JAL:     state_d = ALUWB;
            LUI:     state_d = ALUWB;
            AUIPC:   state_d = ALUWB;
`ifdef ICYRISC_ILLEGAL_TRAP_EN
            TRAP:    state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state
    always_comb begin
        case (opcode)
            OP_STORE:         imm_ctrl = 3'd1;
            OP_BRANCH:        imm_ctrl = 3'd2;
            OP_LUI, OP_AUIPC: imm_ctrl = 3'd3;
            OP_JAL:           imm_ctrl = 3'd4;
            default:          imm_ctrl = 3'd0;
        endcase
    end

    // Per-state datapath controls; strobes are masked while rst is held
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        result_src = 2'd0;
        case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
            end
            MEMRD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd2;
            end
            EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_op    = 2'd2;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd1;
                pc_write  = branch_taken;
            end
            JALR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
            end
            JAL: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
            end
            LUI: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd1;
            end
            AUIPC: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            default: begin
            end
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

`ifdef ICYRISC_ILLEGAL_TRAP_EN
    assign illegal = (state_q == TRAP);
`endif

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl.
// Expected behaviour comes from a per-instruction list of phases and a table
// of per-phase control values; honours ICYRISC_ILLEGAL_TRAP_EN like the DUT.
module tb_multicycle_ctrl;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_MEMADR = 2;
    localparam int S_MEMRD  = 3;
    localparam int S_MEMWB  = 4;
    localparam int S_MEMWR  = 5;
    localparam int S_EXEC_R = 6;
    localparam int S_EXEC_I = 7;
    localparam int S_ALUWB  = 8;
    localparam int S_BRANCH = 9;
    localparam int S_JALR   = 10;
    localparam int S_JAL    = 11;
    localparam int S_LUI    = 12;
    localparam int S_AUIPC  = 13;
    localparam int S_TRAP   = 14;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        adr_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [2:0]  imm_ctrl;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  result_src;
    logic [3:0]  state_dbg;
`ifdef ICYRISC_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [16:0] outsObs;

    int checks;
    int failures;
    int path[$];
    logic [6:0] opList[$];

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .adr_src      (adr_src),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .imm_ctrl     (imm_ctrl),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .result_src   (result_src),
`ifdef ICYRISC_ILLEGAL_TRAP_EN
        .illegal      (illegal),
`endif
        .state_dbg    (state_dbg)
    );

    assign outsObs = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                      imm_ctrl, alu_src_a, alu_src_b, alu_op, result_src};

    // 10-time-unit core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive all DUT inputs at once
    task automatic applyStimulus(input logic [6:0] op, input logic tk,
                                 input logic rdy, input logic r);
        opcode       = op;
        branch_taken = tk;
        mem_ready    = rdy;
        rst          = r;
    endtask

    // Immediate format each opcode needs
    function automatic logic [2:0] immFor(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    // Control values required in a phase, packed like outsObs
    function automatic logic [16:0] expectOuts(input int ph, input logic [6:0] op,
                                               input logic tk, input logic rdy,
                                               input logic inRst);
        logic pcw, irw, adr, mrd, mwr, rw;
        logic [1:0] a, b, alu, res;
        {pcw, irw, adr, mrd, mwr, rw} = 6'b0;
        {a, b, alu, res} = 8'b0;
        case (ph)
            S_FETCH:  begin mrd = 1; b = 2; res = 2; irw = rdy; pcw = rdy; end
            S_DECODE: begin a = 1; b = 1; end
            S_MEMADR: begin a = 2; b = 1; end
            S_MEMRD:  begin adr = 1; mrd = 1; end
            S_MEMWB:  begin res = 1; rw = 1; end
            S_MEMWR:  begin adr = 1; mwr = 1; end
            S_EXEC_R: begin a = 2; b = 0; alu = 2; end
            S_EXEC_I: begin a = 2; b = 1; alu = 2; end
            S_ALUWB:  begin rw = 1; end
            S_BRANCH: begin a = 2; alu = 1; pcw = tk; end
            S_JALR:   begin a = 2; b = 1; end
            S_JAL:    begin a = 1; b = 2; pcw = 1; end
            S_LUI:    begin a = 3; b = 1; end
            S_AUIPC:  begin a = 1; b = 1; end
            default:  begin end
        endcase
        if (inRst) {pcw, irw, mrd, mwr, rw} = 5'b0;
        return {pcw, irw, adr, mrd, mwr, rw, immFor(op), a, b, alu, res};
    endfunction

    // Phases one instruction visits, starting at its fetch
    task automatic buildPath(input logic [6:0] op);
        path = {S_FETCH, S_DECODE};
        case (op)
            7'b0000011: path = {path, S_MEMADR, S_MEMRD, S_MEMWB};
            7'b0100011: path = {path, S_MEMADR, S_MEMWR};
            7'b0110011: path = {path, S_EXEC_R, S_ALUWB};
            7'b0010011: path = {path, S_EXEC_I, S_ALUWB};
            7'b1100011: path = {path, S_BRANCH};
            7'b1101111: path = {path, S_JAL, S_ALUWB};
            7'b1100111: path = {path, S_JALR, S_JAL, S_ALUWB};
            7'b0110111: path = {path, S_LUI, S_ALUWB};
            7'b0010111: path = {path, S_AUIPC, S_ALUWB};
            default:    begin end
        endcase
    endtask

    // Run one instruction from FETCH, checking every cycle against the model
    task automatic runInstr(input logic [6:0] op, input bit forceReady);
        int idx;
        int stallRun;
        int ph;
        logic tk;
        logic rdy;
        buildPath(op);
        idx = 0;
        stallRun = 0;
        while (idx < path.size()) begin
            @(negedge clk);
            tk  = 1'($urandom_range(0, 1));
            rdy = (forceReady || stallRun >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            applyStimulus(op, tk, rdy, 1'b0);
            #1;
            ph = path[idx];
            checkOutput($sformatf("state op=%b step=%0d", op, idx), 32'(state_dbg), ph);
            checkOutput($sformatf("outs op=%b step=%0d", op, idx), 32'(outsObs),
                        32'(expectOuts(ph, op, tk, rdy, 1'b0)));
`ifdef ICYRISC_ILLEGAL_TRAP_EN
            checkOutput("illegal low", 32'(illegal), 0);
`endif
            if ((ph == S_FETCH || ph == S_MEMRD || ph == S_MEMWR) && !rdy) begin
                stallRun++;
            end else begin
                stallRun = 0;
                idx++;
            end
        end
    endtask

    // Hold rst for a few cycles checking masked strobes, then release in FETCH
    task automatic holdResetAndRelease(input logic [6:0] op);
        logic rdy;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            applyStimulus(op, 1'b1, rdy, 1'b1);
            #1;
            checkOutput("reset state", 32'(state_dbg), S_FETCH);
            checkOutput("reset outs", 32'(outsObs), 32'(expectOuts(S_FETCH, op, 1'b1, rdy, 1'b1)));
`ifdef ICYRISC_ILLEGAL_TRAP_EN
            checkOutput("reset illegal", 32'(illegal), 0);
`endif
        end
        @(negedge clk);
        applyStimulus(op, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("release state", 32'(state_dbg), S_FETCH);
        checkOutput("release outs", 32'(outsObs), 32'(expectOuts(S_FETCH, op, 1'b0, 1'b0, 1'b0)));
    endtask

    // Main sequence: reset, directed pass, random pass, reset mid-store, illegal opcode
    initial begin
        checks   = 0;
        failures = 0;
        opList = {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
`ifndef ICYRISC_ILLEGAL_TRAP_EN
        opList = {opList, 7'b0000000, 7'b1111111, 7'b0001111};
`endif
        applyStimulus(7'b0110011, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("por state", 32'(state_dbg), S_FETCH);
        holdResetAndRelease(7'b0110011);

        foreach (opList[i]) runInstr(opList[i], 1'b1);
        for (int n = 0; n < 80; n++) begin
            runInstr(opList[$urandom_range(0, opList.size() - 1)], 1'b0);
        end

        // Store held in MEMWR by mem_ready=0, then async reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(7'b0100011, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk);
        applyStimulus(7'b0100011, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("store stall state", 32'(state_dbg), S_MEMWR);
        checkOutput("store stall outs", 32'(outsObs),
                    32'(expectOuts(S_MEMWR, 7'b0100011, 1'b0, 1'b0, 1'b0)));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset state", 32'(state_dbg), S_FETCH);
        checkOutput("async reset mem_write", 32'(mem_write), 0);
        checkOutput("async reset outs", 32'(outsObs),
                    32'(expectOuts(S_FETCH, 7'b0100011, 1'b0, 1'b0, 1'b1)));
        holdResetAndRelease(7'b0100011);
        runInstr(7'b0000011, 1'b0);

`ifdef ICYRISC_ILLEGAL_TRAP_EN
        runInstr(7'b0000000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(7'b0000000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            #1;
            checkOutput("trap state", 32'(state_dbg), S_TRAP);
            checkOutput("trap illegal", 32'(illegal), 1);
            checkOutput("trap outs", 32'(outsObs),
                        32'(expectOuts(S_TRAP, 7'b0000000, branch_taken, mem_ready, 1'b0)));
        end
        #1;
        rst = 1'b1;
        #1;
        checkOutput("trap cleared", 32'(illegal), 0);
        holdResetAndRelease(7'b0000000);
`else
        runInstr(7'b0000000, 1'b1);
`endif
        runInstr(7'b0110011, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
